mem_uart_bridge: RTL and testbench
==================================

// Module: mem_uart_bridge
// PURPOSE
//   Single-clock bridge between the CPU memory stage and the shared SRAM/UART data bus.
//   Uses a valid/ready request with a one-cycle response pulse.
//   Adds a parametrised RX FIFO, a status register, programmable SRAM wait states and a TX timeout.
// PARAMETERS
//   ADDR_W          18       request/SRAM address width
//   DATA_W          16       data word width (UART uses bits [7:0])
//   FIFO_AW         4        RX FIFO depth = 2**FIFO_AW words
//   SRAM_WAIT       1        extra cycles added to each SRAM/RX strobe (0..15)
//   TX_TIMEOUT      1024     max cycles waiting for tbre&tsre before error
//   UART_DATA_ADDR  'hBF00   UART data register address
//   UART_STAT_ADDR  'hBF01   UART status/control register address
// PORTS
//   clk             in   1        clock, all state on rising edge
//   rst             in   1        asynchronous reset, active-high
//   req_valid       in   1        request present
//   req_wr          in   1        1=write, 0=read
//   req_addr        in   ADDR_W   request address
//   req_wdata       in   DATA_W   write data
//   req_ready       out  1        request accepted on req_valid&req_ready edge
//   resp_valid      out  1        one-cycle completion pulse
//   resp_rdata      out  DATA_W   read data, held until next resp_valid
//   resp_err        out  1        valid with resp_valid: TX timeout or empty-FIFO read
//   sram_addr       out  ADDR_W   latched request address
//   sram_data       inout DATA_W  shared SRAM/UART bus, 'z unless driving
//   sram_ce_n/sram_oe_n/sram_we_n out 1 each  SRAM strobes, active-low
//   uart_data_ready in   1        UART byte available
//   uart_rdn        out  1        UART read strobe, active-low
//   uart_tbre, uart_tsre  in 1 each  UART TX buffer empty / shift register empty
//   uart_wrn        out  1        UART write strobe, active-low
//   rx_count        out  FIFO_AW+1  FIFO occupancy 0..2**FIFO_AW
// BEHAVIOUR
// - Reset (async, immediate): state IDLE; all strobes 1; bus 'z; FIFO empty.
//   resp_valid/resp_err 0; resp_rdata 0; sram_addr 0.
// - req_ready = (state==IDLE) & ~(uart_data_ready & ~fifo_full).
//   On accept, addr/wdata/wr are latched. RX has priority over a same-cycle request.
// - IDLE with uart_data_ready & FIFO full: RX is deferred and uart_rdn stays 1; no data is lost.
// - SRAM read (E0 = accept edge): RD state, ce_n=oe_n=0, for SRAM_WAIT+1 cycles.
//   At E0+SRAM_WAIT+1: sample bus into resp_rdata, resp_valid=1, go IDLE.
// - SRAM write: WR_SETUP 1 cycle (ce_n=0, bus driven) -> WR_PULSE SRAM_WAIT+1 cycles (we_n=0)
//   -> WR_HOLD 1 cycle (we_n=1, bus still driven). resp_valid at E0+SRAM_WAIT+3.
// - RX: RX_STROBE, uart_rdn=0 for SRAM_WAIT+1 cycles, ce_n=1, bus 'z.
//   At exit, push {0, bus[7:0]} into FIFO. RX_RECOVER 1 cycle (rdn=1, ignore data_ready) -> IDLE.
// - UART_DATA read: next edge resp_valid=1. Non-empty: rdata = head, pop.
//   Empty: rdata=0, resp_err=1, no pop.
// - UART_STAT read: next edge resp_valid=1. rdata = {0, rx_count, fifo_full, tx_idle, fifo_nonempty}.
//   fifo_nonempty is bit 0; rx_count starts at bit 3.
//   tx_idle = tbre&tsre.
// - UART_STAT write: next edge resp_valid=1; wdata[0]=1 flushes FIFO (rx_count=0).
// - A same-cycle RX push is impossible: a flush happens only in an access state.
// - UART_DATA write: TX_SETUP 1 cycle (bus driven, wrn=1) -> TX_STROBE 1 cycle (wrn=0)
//   -> TX_WAIT (wrn=1, bus driven) until tbre&tsre, then resp_valid.
//   If TX_TIMEOUT cycles elapse in TX_WAIT: resp_valid=1, resp_err=1, go IDLE.
// - Bus driven only in WR_*/TX_* states; never driven while oe_n=0 or rdn=0.
// - FIFO pointers are FIFO_AW+1 bits and wrap modulo 2**(FIFO_AW+1).
//   full = MSBs differ & low bits equal.
// - resp_err=0 on every resp_valid except the two cases above.
// TESTING
// - SRAM_WAIT=1: write 'h1234 @'h00010, read it back -> resp_valid at E0+4 (write), E0+2 (read).
//   Read returns 'h1234; oe_n/we_n never low together.
// - Three RX bytes 'h41,'h42,'h43 -> rx_count=3.
//   Three UART_DATA reads return 'h0041,'h0042,'h0043; a 4th read returns 0 with resp_err=1.
// - Fill FIFO (16 bytes) with data_ready held -> rdn stays 1, rx_count=16, status bit2=1.
//   One pop -> 17th byte accepted.
// - data_ready and req_valid in the same cycle -> req_ready=0, RX completes first, then request accepted.
// - TX with tsre stuck 0 -> resp_err=1 exactly TX_TIMEOUT cycles after entering TX_WAIT.
//   tsre=1 after 5 cycles -> clean response.
// - Assert rst mid-WR_PULSE -> we_n=1, bus 'z and rx_count=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/mem_uart_bridge_if.sv
// mem_uart_bridge_if: CPU-side valid/ready request with a one-cycle response pulse.
interface mem_uart_bridge_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_uart_bridge.sv
// mem_uart_bridge: single-clock bridge from the CPU memory stage to the shared SRAM/UART bus,
// with an RX byte FIFO, a UART status register, SRAM wait states and a TX completion timeout.
module mem_uart_bridge #(
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int FIFO_AW        = 4,
    parameter int SRAM_WAIT      = 1,
    parameter int TX_TIMEOUT     = 1024,
    parameter int UART_DATA_ADDR = 'hBF00,
    parameter int UART_STAT_ADDR = 'hBF01
) (
    input  logic              clk,
    input  logic              rst,
    mem_uart_bridge_if.slave  bus,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire  [DATA_W-1:0] sram_data_io,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    input  logic              uart_data_ready_i,
    output logic              uart_rdn_o,
    input  logic              uart_tbre_i,
    input  logic              uart_tsre_i,
    output logic              uart_wrn_o,
    output logic [FIFO_AW:0]  rx_count_o
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(TX_TIMEOUT + 16);
    localparam logic [ADDR_W-1:0] DATA_A = ADDR_W'(UART_DATA_ADDR);
    localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(UART_STAT_ADDR);

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_RX_STROBE, S_RX_RECOVER,
        S_UREG, S_TX_SETUP, S_TX_STROBE, S_TX_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              wr_q, wr_d, rv_q, rv_d, err_q, err_d;
    logic [FIFO_AW:0]  wp_q, wp_d, rp_q, rp_d;
    logic [7:0]        mem_q [DEPTH];
    logic              push, full, empty, rx_go, wait_done, tx_idle, drive;
    logic [DATA_W-1:0] status;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full       = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) && (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
    assign empty      = wp_q == rp_q;
    assign rx_count_o = wp_q - rp_q;
    assign tx_idle    = uart_tbre_i & uart_tsre_i;
    assign rx_go      = uart_data_ready_i & ~full;
    assign wait_done  = cnt_q == CW'(SRAM_WAIT);
    assign status     = DATA_W'({rx_count_o, full, tx_idle, ~empty});

    assign bus.req_ready  = (state_q == S_IDLE) & ~rx_go;
    assign bus.resp_valid = rv_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign sram_addr_o    = addr_q;

    // Strobes decode straight from state so an async reset releases them at once.
    assign sram_ce_n_o  = !(state_q inside {S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
    assign sram_oe_n_o  = state_q != S_RD;
    assign sram_we_n_o  = state_q != S_WR_PULSE;
    assign uart_rdn_o   = state_q != S_RX_STROBE;
    assign uart_wrn_o   = state_q != S_TX_STROBE;
    assign drive        = state_q inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_TX_SETUP, S_TX_STROBE, S_TX_WAIT};
    assign sram_data_io = drive ? wdata_q : 'z;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        rv_d    = 1'b0;
        err_d   = 1'b0;
        wp_d    = wp_q;
        rp_d    = rp_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_go) state_d = S_RX_STROBE;
                else if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    wr_d    = bus.req_wr;
                    state_d = (bus.req_addr == DATA_A) ? (bus.req_wr ? S_TX_SETUP : S_UREG)
                            : (bus.req_addr == STAT_A) ? S_UREG
                            : bus.req_wr ? S_WR_SETUP : S_RD;
                end
            end
            S_RD: if (wait_done) begin
                rdata_d = sram_data_io;
                rv_d    = 1'b1;
                state_d = S_IDLE;
            end
            S_WR_SETUP: begin
                cnt_d   = '0;
                state_d = S_WR_PULSE;
            end
            S_WR_PULSE: if (wait_done) state_d = S_WR_HOLD;
            S_WR_HOLD: begin
                rv_d    = 1'b1;
                state_d = S_IDLE;
            end
            S_RX_STROBE: if (wait_done) begin
                push    = 1'b1;
                wp_d    = wp_q + 1'b1;
                state_d = S_RX_RECOVER;
            end
            S_RX_RECOVER: state_d = S_IDLE;
            S_UREG: begin
                rv_d    = 1'b1;
                state_d = S_IDLE;
                if (wr_q) rp_d = wdata_q[0] ? wp_q : rp_q;
                else if (addr_q == STAT_A) rdata_d = status;
                else if (empty) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    rdata_d = DATA_W'(mem_q[rp_q[FIFO_AW-1:0]]);
                    rp_d    = rp_q + 1'b1;
                end
            end
            S_TX_SETUP: state_d = S_TX_STROBE;
            S_TX_STROBE: begin
                cnt_d   = '0;
                state_d = S_TX_WAIT;
            end
            S_TX_WAIT: if (tx_idle || cnt_q == CW'(TX_TIMEOUT - 1)) begin
                rv_d    = 1'b1;
                err_d   = ~tx_idle;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q[FIFO_AW-1:0]] <= sram_data_io[7:0];
    end
endmodule

// File: tb/tb_mem_uart_bridge.sv
// tb_mem_uart_bridge: randomized requests against a queue/array reference model; a monitor
// pops expected responses from a scoreboard whenever resp_valid pulses.
module tb_mem_uart_bridge;
    localparam int SW = 1;
    localparam int TO = 1024;
    localparam logic [17:0] DA = 18'hBF00;
    localparam logic [17:0] SA = 18'hBF01;

    typedef struct {
        logic [15:0] rd;
        logic        err;
        logic        chk_rd;
        int          lat;
        int          e0;
        int          tag;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic [17:0] sram_addr;
    wire  [15:0] sram_data;
    logic        ce_n, oe_n, we_n, rdn, wrn;
    logic        tbre = 1, tsre = 1;
    logic [4:0]  rx_count;
    logic [15:0] sram [1024];
    logic [7:0]  rx_bytes [256];
    int          rx_wr_n = 0, rx_rd_n = 0, cyc = 0, tests = 0, fails = 0;
    logic        overlap = 0;
    exp_t        sb [$];
    logic [7:0]  ref_fifo [$];
    logic [7:0]  tx_exp [$];
    logic [15:0] ref_mem [int];
    logic [17:0] written [$];
    wire         dready = rx_wr_n != rx_rd_n;

    mem_uart_bridge_if #(.ADDR_W(18), .DATA_W(16)) bus ();

    mem_uart_bridge #(.SRAM_WAIT(SW), .TX_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sram_addr_o(sram_addr), .sram_data_io(sram_data),
        .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n),
        .uart_data_ready_i(dready), .uart_rdn_o(rdn),
        .uart_tbre_i(tbre), .uart_tsre_i(tsre), .uart_wrn_o(wrn),
        .rx_count_o(rx_count)
    );

    // SRAM and UART-RX drive the shared bus only while their read strobe is low.
    assign sram_data = (!ce_n && !oe_n) ? sram[sram_addr[9:0]]
                     : !rdn ? {8'h00, rx_bytes[rx_rd_n[7:0]]} : 16'hzzzz;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (!ce_n && !we_n) sram[sram_addr[9:0]] <= sram_data;
    always @(oe_n or we_n) if (oe_n === 1'b0 && we_n === 1'b0) overlap = 1;

    always @(posedge rdn) if (!rst) begin
        ref_fifo.push_back(rx_bytes[rx_rd_n[7:0]]);
        rx_rd_n++;
    end

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s tag=%0d actual=%0h expected=%0h", nm, tag, act, exp);
        end
    endtask

    always @(negedge wrn) if (!rst) begin
        if (tx_exp.size() == 0) chk("tx_unexpected", 0, 32'(sram_data[7:0]), 32'hFFFF_FFFF);
        else chk("tx_byte", 0, 32'(sram_data[7:0]), 32'(tx_exp.pop_front()));
    end

    always @(negedge clk) if (!rst && bus.resp_valid) begin : mon
        exp_t e;
        if (sb.size() == 0) chk("resp_unexpected", 0, 32'(bus.resp_rdata), 32'hFFFF_FFFF);
        else begin
            e = sb.pop_front();
            chk("resp_err", e.tag, 32'(bus.resp_err), 32'(e.err));
            if (e.chk_rd) chk("resp_rdata", e.tag, 32'(bus.resp_rdata), 32'(e.rd));
            if (e.lat >= 0) chk("resp_latency", e.tag, cyc - e.e0, e.lat);
        end
    end

    task automatic do_req(input logic wr, input logic [17:0] a, input logic [15:0] d,
                          input int lat, input logic tx_err, input int tag);
        exp_t e;
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1; bus.req_wr = wr; bus.req_addr = a; bus.req_wdata = d;
        #1;
        while (!bus.req_ready && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", tag, 0, 1);
            bus.req_valid = 0;
            return;
        end
        e = '{rd: 16'h0, err: 1'b0, chk_rd: 1'b0, lat: lat, e0: cyc + 1, tag: tag};
        if (a == DA && wr) begin
            e.err = tx_err;
            tx_exp.push_back(d[7:0]);
        end else if (a == DA) begin
            e.chk_rd = 1;
            if (ref_fifo.size() == 0) e.err = 1;
            else e.rd = {8'h00, ref_fifo.pop_front()};
        end else if (a == SA && !wr) begin
            e.chk_rd = 1;
            e.rd = {8'h00, 5'(ref_fifo.size()), ref_fifo.size() == 16, tbre & tsre, ref_fifo.size() != 0};
        end else if (a == SA) begin
            if (d[0]) ref_fifo.delete();
        end else if (wr) begin
            ref_mem[int'(a)] = d;
            written.push_back(a);
        end else begin
            e.chk_rd = 1;
            e.rd = ref_mem[int'(a)];
        end
        sb.push_back(e);
        @(posedge clk);
        #1 bus.req_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb[0].tag, 32'(sb.size()), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic rx_add(input logic [7:0] b);
        rx_bytes[rx_wr_n[7:0]] = b;
        rx_wr_n++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic held;
        bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = '0; bus.req_wdata = '0;
        #2;
        chk("rst_ce_n", 0, 32'(ce_n), 1);
        chk("rst_oe_n", 0, 32'(oe_n), 1);
        chk("rst_we_n", 0, 32'(we_n), 1);
        chk("rst_rdn", 0, 32'(rdn), 1);
        chk("rst_wrn", 0, 32'(wrn), 1);
        chk("rst_resp_valid", 0, 32'(bus.resp_valid), 0);
        chk("rst_resp_err", 0, 32'(bus.resp_err), 0);
        chk("rst_rdata", 0, 32'(bus.resp_rdata), 0);
        chk("rst_addr", 0, 32'(sram_addr), 0);
        chk("rst_rx_count", 0, 32'(rx_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        // SRAM write then read back with wait-state latencies
        do_req(1, 18'h00010, 16'h1234, SW + 3, 0, 1); drain();
        do_req(0, 18'h00010, 16'h0000, SW + 1, 0, 2); drain();
        // three RX bytes, three reads, then an empty read
        rx_add(8'h41); rx_add(8'h42); rx_add(8'h43);
        repeat (20) @(negedge clk);
        chk("rx3_count", 3, 32'(rx_count), 3);
        for (int i = 0; i < 4; i++) begin
            do_req(0, DA, 16'h0, 1, 0, 10 + i);
            drain();
        end
        // fill FIFO with one extra byte pending
        for (int i = 0; i < 17; i++) rx_add(8'($urandom));
        repeat (100) @(negedge clk);
        chk("full_count", 20, 32'(rx_count), 16);
        held = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rdn) held = 0;
        end
        chk("full_rdn_held", 21, 32'(held), 1);
        do_req(0, SA, 16'h0, 1, 0, 22); drain();
        chk("full_stat_bit2", 22, 32'(bus.resp_rdata[2]), 1);
        do_req(0, DA, 16'h0, 1, 0, 23); drain();
        repeat (15) @(negedge clk);
        chk("refill_count", 24, 32'(rx_count), 16);
        chk("refill_ready", 24, 32'(dready), 0);
        do_req(1, SA, 16'h0001, 1, 0, 25); drain();
        chk("flush_count", 25, 32'(rx_count), 0);
        // RX and request presented together: RX must win
        @(negedge clk);
        rx_add(8'h55);
        bus.req_valid = 1; bus.req_wr = 0; bus.req_addr = SA;
        #1 chk("prio_ready", 30, 32'(bus.req_ready), 0);
        do_req(0, SA, 16'h0, 1, 0, 31); drain();
        do_req(0, DA, 16'h0, 1, 0, 32); drain();
        // TX timeout, then a TX that completes after a few cycles
        tsre = 0;
        do_req(1, DA, 16'h00A5, TO + 2, 1, 40); drain();
        do_req(1, DA, 16'h005A, -1, 0, 41);
        repeat (5) @(negedge clk);
        tsre = 1;
        drain();
        // randomized traffic
        for (int it = 0; it < 120; it++) begin
            int k = $urandom_range(0, 7);
            logic [17:0] a = 18'($urandom_range(0, 1023));
            logic [15:0] d = 16'($urandom);
            if (k == 2 && written.size() == 0) k = 0;
            case (k)
                0, 1: do_req(1, a, d, SW + 3, 0, 100 + it);
                2:    do_req(0, written[$urandom_range(0, written.size() - 1)], 16'h0, SW + 1, 0, 100 + it);
                3:    begin rx_add(8'($urandom)); do_req(0, SA, 16'h0, 1, 0, 100 + it); end
                4:    do_req(0, DA, 16'h0, 1, 0, 100 + it);
                5:    do_req(0, SA, 16'h0, 1, 0, 100 + it);
                6:    do_req(1, SA, d, 1, 0, 100 + it);
                default: do_req(1, DA, d, 3, 0, 100 + it);
            endcase
            drain();
        end
        // async reset in the middle of a write pulse
        rx_add(8'h11); rx_add(8'h22);
        repeat (20) @(negedge clk);
        do_req(1, 18'h00020, 16'hBEEF, -1, 0, 300);
        for (int i = 0; i < 10 && we_n !== 1'b0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("pulse_reached", 300, 32'(we_n), 0);
        #2 rst = 1;
        #1;
        chk("arst_we_n", 300, 32'(we_n), 1);
        chk("arst_ce_n", 300, 32'(ce_n), 1);
        chk("arst_bus_released", 300, 32'(sram_data !== 16'hBEEF), 1);
        chk("arst_rx_count", 300, 32'(rx_count), 0);
        sb.delete(); ref_fifo.delete(); tx_exp.delete();
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("oe_we_overlap", 0, 32'(overlap), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
